// File: rtl/gb_video_pkg.sv
// rtl/gb_video_pkg.sv - shared GameBoy video constants and arbiter FSM encoding
package gb_video_pkg;

    localparam int GB_W   = 160;
    localparam int GB_H   = 144;
    localparam int GB_WPL = 40;
    localparam int FB_AW  = 13;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/gb_line_buffer.sv
// rtl/gb_line_buffer.sv - ping-pong line buffer: fill-bank write port, registered pixel read
module gb_line_buffer #(
    parameter int WPL = 40,
    parameter int WW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [WW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          swap_i,
    input  logic [7:0]    rd_x_i,
    output logic [1:0]    rd_pix_o,
    output logic          disp_bank_o
);

    logic [7:0] buf_q [2][WPL];
    logic       bank_q;
    logic [1:0] pix_q;
    logic [1:0] pix_d;
    logic [7:0] rd_byte;

    // Four 2-bit pixels per byte, pixel 0 in the low bits; off-screen x reads as 0.
    always_comb begin
        pix_d   = '0;
        rd_byte = '0;
        if (rd_x_i < 8'(WPL * 4)) begin
            rd_byte = buf_q[bank_q][rd_x_i[7:2]];
            pix_d   = rd_byte[{rd_x_i[1:0], 1'b0} +: 2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < WPL; i++) begin
                    buf_q[b][i] <= '0;
                end
            end
            bank_q <= 1'b0;
            pix_q  <= '0;
        end else begin
            if (we_i) begin
                buf_q[~bank_q][waddr_i] <= wdata_i;
            end
            if (swap_i) begin
                bank_q <= ~bank_q;
            end
            pix_q <= pix_d;
        end
    end

    assign rd_pix_o    = pix_q;
    assign disp_bank_o = bank_q;

endmodule

// File: rtl/gb_fb_arbiter.sv
// rtl/gb_fb_arbiter.sv - framebuffer RAM arbiter: scanout line prefetch with PPU write fill-in
module gb_fb_arbiter
    import gb_video_pkg::*;
#(
    parameter int WPL     = GB_WPL,
    parameter int LINES   = GB_H,
    parameter int AW      = FB_AW,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          line_req,
    input  logic [7:0]    line_y,
    input  logic [7:0]    rd_x,
    output logic [1:0]    rd_pix,
    output logic          disp_bank,
    output logic          busy,
    output logic          err_overrun,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int WW = $clog2(WPL);

    logic [1:0]    state_q, state_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_y_q, pend_y_d;
    logic [AW-1:0] base_q, base_d;
    logic [WW-1:0] w_q, w_d;
    logic [1:0]    drn_q, drn_d;
    logic          err_q, err_d;
    logic          swap;
    logic          req_ok;
    logic [7:0]    launch_y;
    logic          wr_go;

    logic [MEM_LAT-1:0] ret_v_q;
    logic [WW-1:0]      ret_w_q [MEM_LAT];

    assign req_ok = line_req && (line_y < 8'(LINES));

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        pend_y_d = pend_y_q;
        base_d   = base_q;
        w_d      = w_q;
        drn_d    = drn_q;
        err_d    = err_q;
        swap     = 1'b0;
        launch_y = pend_y_q;

        if (req_ok) begin
            pend_d   = 1'b1;
            pend_y_d = line_y;
            if (pend_q) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A request landing on the launch edge overwrites the pending line before it is used.
                if (pend_q) begin
                    launch_y = req_ok ? line_y : pend_y_q;
                    base_d   = (AW'(launch_y) << 5) + (AW'(launch_y) << 3);
                    pend_d   = 1'b0;
                    w_d      = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_d = w_q + 1'b1;
                if (w_q == WW'(WPL - 1)) begin
                    drn_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drn_q == 2'(MEM_LAT - 1)) begin
                    swap    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            pend_y_q <= '0;
            base_q   <= '0;
            w_q      <= '0;
            drn_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_y_q <= pend_y_d;
            base_q   <= base_d;
            w_q      <= w_d;
            drn_q    <= drn_d;
            err_q    <= err_d;
        end
    end

    // Word index travels alongside the RAM read so returning data lands in the right slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_v_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                ret_w_q[i] <= '0;
            end
        end else begin
            ret_v_q[0] <= (state_q == ST_FETCH);
            ret_w_q[0] <= w_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                ret_v_q[i] <= ret_v_q[i-1];
                ret_w_q[i] <= ret_w_q[i-1];
            end
        end
    end

    assign wr_ready = !reset && (state_q == ST_IDLE) && !pend_q && !line_req;
    assign wr_go    = wr_valid && wr_ready;

    assign mem_addr    = (state_q == ST_FETCH) ? (base_q + AW'(w_q)) : (wr_go ? wr_addr : '0);
    assign mem_we      = wr_go;
    assign mem_wdata   = wr_go ? wr_data : '0;
    assign busy        = pend_q || (state_q != ST_IDLE);
    assign err_overrun = err_q;

    gb_line_buffer #(
        .WPL (WPL),
        .WW  (WW)
    ) u_line_buffer (
        .clk         (clk),
        .reset       (reset),
        .we_i        (ret_v_q[MEM_LAT-1]),
        .waddr_i     (ret_w_q[MEM_LAT-1]),
        .wdata_i     (mem_rdata),
        .swap_i      (swap),
        .rd_x_i      (rd_x),
        .rd_pix_o    (rd_pix),
        .disp_bank_o (disp_bank)
    );

endmodule

// File: tb/tb_gb_fb_arbiter.sv
// tb/tb_gb_fb_arbiter.sv - randomized self-checking bench for gb_fb_arbiter
module tb_gb_fb_arbiter;
    import gb_video_pkg::*;

    localparam int ML  = 1;
    localparam int WPL = GB_WPL;
    localparam int AW  = FB_AW;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          line_req;
    logic [7:0]    line_y;
    logic [7:0]    rd_x;
    logic [1:0]    rd_pix;
    logic          disp_bank;
    logic          busy;
    logic          err_overrun;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [7:0] ram    [8192];
    logic [7:0] shadow [8192];
    logic [7:0] rpipe  [ML];
    logic       loaded = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_bank = 0;
    int req_q[$];
    int exp_q[$];

    gb_fb_arbiter #(
        .WPL     (WPL),
        .LINES   (GB_H),
        .AW      (AW),
        .MEM_LAT (ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .line_req    (line_req),
        .line_y      (line_y),
        .rd_x        (rd_x),
        .rd_pix      (rd_pix),
        .disp_bank   (disp_bank),
        .busy        (busy),
        .err_overrun (err_overrun),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with ML-cycle read latency, preloaded with word k = k[7:0].
    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 8192; k++) ram[k] <= 8'(k);
            loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        rpipe[0] <= ram[mem_addr];
        for (int i = 1; i < ML; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[ML-1];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pix(input int y, input int x);
        logic [7:0] b;
        if (x >= GB_W) return 0;
        b = shadow[y * WPL + x / 4];
        return int'((b >> (2 * (x % 4))) & 8'h3);
    endfunction

    task automatic check_pix_one(input int y, input int x);
        @(negedge clk);
        rd_x = 8'(x);
        @(negedge clk);
        chk_eq($sformatf("rd_pix y%0d x%0d", y, x), 32'(rd_pix), 32'(exp_pix(y, x)));
    endtask

    task automatic check_pixels(input int y);
        int x;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: x = 0;
                1: x = 4;
                2: x = 159;
                3: x = 160;
                4: x = 255;
                default: x = $urandom_range(0, 159);
            endcase
            check_pix_one(y, x);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, " wr_ready"},    32'(wr_ready),    0);
        chk_eq({tag, " mem_we"},      32'(mem_we),      0);
        chk_eq({tag, " mem_addr"},    32'(mem_addr),    0);
        chk_eq({tag, " mem_wdata"},   32'(mem_wdata),   0);
        chk_eq({tag, " rd_pix"},      32'(rd_pix),      0);
        chk_eq({tag, " disp_bank"},   32'(disp_bank),   0);
        chk_eq({tag, " busy"},        32'(busy),        0);
        chk_eq({tag, " err_overrun"}, 32'(err_overrun), 0);
    endtask

    task automatic do_write(input int a, input int d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = 8'(d);
        #1;
        chk_eq("wr ready_idle", 32'(wr_ready),  1);
        chk_eq("wr mem_we",     32'(mem_we),    1);
        chk_eq("wr mem_addr",   32'(mem_addr),  32'(a));
        chk_eq("wr mem_wdata",  32'(mem_wdata), 32'(d & 8'hFF));
        @(negedge clk);
        wr_valid = 1'b0;
        shadow[a] = 8'(d);
    endtask

    // Model: requests pulse on consecutive cycles from cycle 0; queued fetches run back to back,
    // each fetch j issuing WPL addresses from cycle 2+j*(WPL+ML+1), its bank visible WPL+ML later.
    task automatic run_fetch(input string tag);
        int nreq, m, total, s, ea, toggles, bank0;
        int bad_addr, we_cnt, bad_bank;
        nreq = req_q.size();
        m = exp_q.size();
        bank0 = exp_bank;
        total = 2 + m * (WPL + ML + 1);
        bad_addr = 0; we_cnt = 0; bad_bank = 0;
        @(negedge clk);
        line_req = 1'b1;
        line_y = 8'(req_q[0]);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k < nreq) begin
                line_req = 1'b1;
                line_y = 8'(req_q[k]);
            end else begin
                line_req = 1'b0;
            end
            ea = -1;
            toggles = 0;
            for (int j = 0; j < m; j++) begin
                s = 2 + j * (WPL + ML + 1);
                if (k >= s && k < s + WPL) ea = exp_q[j] * WPL + (k - s);
                if (k >= s + WPL + ML) toggles++;
            end
            if (ea >= 0 && 32'(mem_addr) !== 32'(ea)) bad_addr++;
            if (mem_we !== 1'b0) we_cnt++;
            if (32'(disp_bank) !== 32'(bank0 ^ (toggles & 1))) bad_bank++;
        end
        exp_bank = bank0 ^ (m & 1);
        chk_eq({tag, " addr_mismatches"}, 32'(bad_addr), 0);
        chk_eq({tag, " we_during_fetch"}, 32'(we_cnt), 0);
        chk_eq({tag, " bank_timing"},     32'(bad_bank), 0);
        chk_eq({tag, " busy_end"},        32'(busy), 0);
        chk_eq({tag, " disp_bank_end"},   32'(disp_bank), 32'(exp_bank));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int y, wa, wd, stall, wec, done, bcnt;
        clk = 0; reset = 0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        line_req = 0; line_y = '0; rd_x = '0;
        for (int k = 0; k < 8192; k++) shadow[k] = 8'(k);
        #1 reset = 1;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 0;

        req_q = {2}; exp_q = {2};
        run_fetch("line2");
        check_pix_one(2, 4);
        check_pixels(2);

        do_write(32'h100, 32'hA5);
        req_q = {6}; exp_q = {6};
        run_fetch("line6");
        check_pix_one(6, 16);
        check_pix_one(6, 19);
        check_pix_one(6, 64);
        check_pix_one(6, 67);

        // Writer held off by a fetch request arriving in the same cycle.
        @(negedge clk);
        wa = 280 + $urandom_range(0, 39);
        wd = $urandom_range(0, 255);
        wr_valid = 1'b1; wr_addr = AW'(wa); wr_data = 8'(wd);
        line_req = 1'b1; line_y = 8'd0;
        #1;
        chk_eq("cont ready_on_req", 32'(wr_ready), 0);
        chk_eq("cont we_on_req",    32'(mem_we), 0);
        @(negedge clk);
        line_req = 1'b0;
        stall = 0; wec = 0; done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            #1;
            if (wr_ready) begin
                done = 1;
                chk_eq("cont accept_we",   32'(mem_we), 1);
                chk_eq("cont accept_addr", 32'(mem_addr), 32'(wa));
                chk_eq("cont accept_data", 32'(mem_wdata), 32'(wd));
            end else begin
                stall++;
                if (mem_we) wec++;
                @(negedge clk);
            end
        end
        chk_eq("cont accepted", 32'(done), 1);
        chk_eq("cont stall_cycles", 32'(stall), 32'(WPL + ML + 1));
        chk_eq("cont we_while_stalled", 32'(wec), 0);
        @(negedge clk);
        wr_valid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) bcnt++;
        end
        chk_eq("cont no_second_write", 32'(bcnt), 0);
        exp_bank ^= 1;
        check_pixels(0);
        shadow[wa] = 8'(wd);
        req_q = {7}; exp_q = {7};
        run_fetch("line7");
        check_pix_one(7, (wa - 280) * 4 + $urandom_range(0, 3));

        // Out-of-range lines are dropped silently.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            line_req = 1'b1;
            line_y = (t == 0) ? 8'd144 : (t == 1) ? 8'd200 : 8'($urandom_range(144, 255));
            bcnt = 0; wec = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                line_req = 1'b0;
                if (busy) bcnt++;
                if (mem_we || mem_addr != '0) wec++;
            end
            chk_eq("oor busy", 32'(bcnt), 0);
            chk_eq("oor mem_activity", 32'(wec), 0);
            chk_eq("oor err_overrun", 32'(err_overrun), 0);
        end

        for (int r = 0; r < 4; r++) begin
            y = $urandom_range(0, GB_H - 1);
            do_write(y * WPL + $urandom_range(0, WPL - 1), $urandom_range(0, 255));
            do_write($urandom_range(0, GB_H * WPL - 1), $urandom_range(0, 255));
            req_q = {y}; exp_q = {y};
            run_fetch($sformatf("rand%0d", r));
            check_pixels(y);
        end

        // Back-to-back requests: the first is overwritten while pending.
        req_q = {3, 4, 5}; exp_q = {4, 5};
        run_fetch("overrun");
        chk_eq("overrun err_set", 32'(err_overrun), 1);
        check_pixels(5);
        chk_eq("overrun err_sticky", 32'(err_overrun), 1);

        // Reset in the middle of a fetch.
        @(negedge clk);
        line_req = 1'b1; line_y = 8'd9;
        @(negedge clk);
        line_req = 1'b0;
        repeat (WPL / 2 + 1) @(negedge clk);
        chk_eq("midreset pre_addr", 32'(mem_addr), 32'(9 * WPL + WPL / 2));
        reset = 1'b1;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_bank = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_x = 8'($urandom_range(0, 159));
            @(negedge clk);
            chk_eq("midreset cleared_bank", 32'(rd_pix), 0);
        end
        req_q = {1}; exp_q = {1};
        run_fetch("line1_after_reset");
        check_pixels(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
